aud_i2s_tx: RTL and testbench
=============================

AUD_I2S_TX -- requirements
Module: aud_i2s_tx

Interface
REQ-001 Parameter: DATA_W, default 16, sample width in bits.
REQ-002 i_clk  input  1  system clock; the only clock; all flops on its rising edge.
REQ-003 i_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 i_en  input  1  play-enable from the DSP stage; high only while that stage is playing and codec DACLRCK is low.
REQ-005 i_bclk  input  1  codec bit clock, asynchronous to i_clk, at most i_clk/4.
REQ-006 i_daclrck  input  1  codec DAC LR clock; 0 = left half-frame, 1 = right half-frame; asynchronous.
REQ-007 i_dac_data  input  DATA_W  signed sample from the DSP stage; valid only while i_daclrck is low, may be Z/X otherwise.
REQ-008 o_aud_dacdat  output  1  I2S serial data to codec DACDAT.
REQ-009 o_busy  output  1  high while a word is being serialized (states S_WAIT, S_SEND).
REQ-010 o_frame_done  output  1  one-cycle pulse when the right-channel word completes.

Function
REQ-011 i_bclk and i_daclrck SHALL each pass through a 2-flop synchronizer plus one history flop; bclk_fall = history 1 and synced 0; lr_fall / lr_rise defined likewise on synced LRCK.
REQ-012 Hold register SHALL load i_dac_data on lr_fall when i_en is 1, and load 0 on lr_fall when i_en is 0; it is unchanged at all other times.
REQ-013 The same held sample SHALL be sent on both left and right half-frames (mono duplication); i_dac_data is never sampled while LRCK is high.
REQ-014 FSM states: S_IDLE, S_WAIT, S_SEND, S_DONE; 2-bit state register.
REQ-015 S_IDLE -> S_WAIT only on lr_fall with i_en=1; otherwise stays in S_IDLE.
REQ-016 In S_WAIT, S_SEND, S_DONE: lr_fall with i_en=1 or lr_rise SHALL go to S_WAIT; lr_fall with i_en=0 SHALL go to S_IDLE.
REQ-017 Entering S_WAIT SHALL load the shift register from the hold value (the value just latched, if lr_fall), clear the 5-bit bit counter, and drive o_aud_dacdat 0.
REQ-018 S_WAIT: on bclk_fall, drive MSB, shift left, counter = 1, go to S_SEND (one-BCLK I2S delay after the LRCK edge).
REQ-019 S_SEND: on bclk_fall, if counter < DATA_W, drive the next bit and increment; if counter == DATA_W, drive 0 and go to S_DONE.
REQ-020 S_DONE and S_IDLE SHALL hold o_aud_dacdat at 0.
REQ-021 An LRCK edge and bclk_fall in the same cycle: the LRCK edge has priority; no bit is emitted that cycle.
REQ-022 An LRCK edge before DATA_W bits are sent SHALL abort the word (truncate); no error flag.
REQ-023 o_frame_done SHALL pulse for exactly one cycle on the S_SEND->S_DONE transition during a right half-frame only.
REQ-024 o_aud_dacdat SHALL be a registered output; it changes only in the cycle after a detected bclk_fall or LRCK edge.
REQ-025 Latency: the MSB appears within 4 i_clk cycles after the second BCLK falling edge following the LRCK transition at the pins.

Reset
REQ-026 While i_rst_n=0: state S_IDLE; o_aud_dacdat, o_busy, o_frame_done, hold, shift register, counter and all synchronizer/history flops = 0.
REQ-027 After release, no bit SHALL be emitted before the first lr_fall with i_en=1; reset mid-word discards the word.

Verification
REQ-028 i_clk/8 BCLK, 32 BCLK per half-frame, i_en=1, i_dac_data=16'hA5C3 at left start -> 1010010111000011 on BCLK falls 2..17 of both halves, then 0; o_frame_done once per frame.
REQ-029 i_en=0 for 4 frames -> o_aud_dacdat constant 0, o_busy 0, o_frame_done never pulses.
REQ-030 i_dac_data driven X while LRCK high -> right half still sends 16'hA5C3; no X on o_aud_dacdat.
REQ-031 Half-frames of only 8 BCLK -> words truncated to 7 bits, next MSB one BCLK after each edge, o_frame_done never pulses.
REQ-032 i_rst_n pulsed low at bit 6 of a word -> all outputs 0 in the next cycle; silence until next lr_fall with i_en=1.
REQ-033 Samples 16'h8000 then 16'h0001 -> first bit only 1, then last bit only 1; o_aud_dacdat returns to 0 after the LSB.

Source files
------------

// File: rtl/aud_i2s_tx.sv
// I2S transmitter: serializes one held mono sample onto DACDAT for both LRCK half-frames,
// MSB first, one BCLK after each LRCK edge, with codec clocks synchronized into i_clk.
module aud_i2s_tx #(
  parameter int unsigned DATA_W = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_bclk,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_dac_data,
  output logic              o_aud_dacdat,
  output logic              o_busy,
  output logic              o_frame_done
);

  localparam int unsigned CntW = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(DATA_W);

  typedef enum logic [1:0] {StIdle, StWait, StSend, StDone} state_e;

  state_e            state_q, state_d;
  logic [1:0]        bclk_sync_q, lr_sync_q;
  logic              bclk_hist_q, lr_hist_q;
  logic [DATA_W-1:0] hold_q, hold_d;
  logic [DATA_W-1:0] shift_q, shift_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              dat_q, dat_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic bclk_fall, lr_fall, lr_rise, restart;

  assign bclk_fall = bclk_hist_q & ~bclk_sync_q[1];
  assign lr_fall   = lr_hist_q & ~lr_sync_q[1];
  assign lr_rise   = ~lr_hist_q & lr_sync_q[1];

  // A muted lr_fall drops to idle; any other LRCK edge (re)starts a word from the hold value.
  assign restart = (lr_fall & i_en) | (lr_rise & (state_q != StIdle));

  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    dat_d   = dat_q;
    done_d  = 1'b0;

    if (lr_fall) begin
      hold_d = i_en ? i_dac_data : '0;
    end

    if (restart) begin
      state_d = StWait;
      shift_d = hold_d;
      cnt_d   = '0;
      dat_d   = 1'b0;
    end else if (lr_fall) begin
      state_d = StIdle;
      dat_d   = 1'b0;
    end else if (bclk_fall) begin
      case (state_q)
        StWait: begin
          dat_d   = shift_q[DATA_W-1];
          shift_d = shift_q << 1;
          cnt_d   = CntW'(1);
          state_d = StSend;
        end
        StSend: begin
          if (cnt_q < CntMax) begin
            dat_d   = shift_q[DATA_W-1];
            shift_d = shift_q << 1;
            cnt_d   = cnt_q + CntW'(1);
          end else begin
            dat_d   = 1'b0;
            state_d = StDone;
            done_d  = lr_sync_q[1];
          end
        end
        default: begin
          dat_d = 1'b0;
        end
      endcase
    end

    busy_d = (state_d == StWait) || (state_d == StSend);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bclk_sync_q <= '0;
      bclk_hist_q <= 1'b0;
      lr_sync_q   <= '0;
      lr_hist_q   <= 1'b0;
      state_q     <= StIdle;
      hold_q      <= '0;
      shift_q     <= '0;
      cnt_q       <= '0;
      dat_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      bclk_sync_q <= {bclk_sync_q[0], i_bclk};
      bclk_hist_q <= bclk_sync_q[1];
      lr_sync_q   <= {lr_sync_q[0], i_daclrck};
      lr_hist_q   <= lr_sync_q[1];
      state_q     <= state_d;
      hold_q      <= hold_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      dat_q       <= dat_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign o_aud_dacdat = dat_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Bench for aud_i2s_tx: acts as the codec clock master, predicts each BCLK bit slot
// from I2S framing rules and checks DACDAT/busy/frame_done at every BCLK rise.
module tb_aud_i2s_tx;

  localparam int unsigned DW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en;
  logic          bclk;
  logic          lrck;
  logic [DW-1:0] data;
  logic          dacdat;
  logic          busy;
  logic          fdone;

  always #5 clk = ~clk;

  aud_i2s_tx #(.DATA_W(DW)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_en         (en),
    .i_bclk       (bclk),
    .i_daclrck    (lrck),
    .i_dac_data   (data),
    .o_aud_dacdat (dacdat),
    .o_busy       (busy),
    .o_frame_done (fdone)
  );

  typedef struct packed {
    logic       dat;
    logic       busy;
    logic [7:0] done;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   done_since = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  always @(negedge clk) if (fdone === 1'b1) done_since++;

  // Monitor: the codec samples DACDAT on each BCLK rise.
  initial begin : monitor
    exp_t e;
    wait (rst_n === 1'b1);
    forever begin
      @(posedge bclk);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL slot_unexpected: got a BCLK slot expected none at %0t", $time);
      end else begin
        e = exp_q.pop_front();
        check("dacdat", {31'd0, dacdat}, {31'd0, e.dat});
        check("busy", {31'd0, busy}, {31'd0, e.busy});
        check("frame_done", done_since, {24'd0, e.done});
      end
      done_since = 0;
    end
  end

  // One half-frame of len BCLK periods; LRCK toggles with the first BCLK fall.
  // Reference: slot 1 is the I2S delay, slots 2..DW+1 carry MSB..LSB, then zero padding;
  // frame_done marks the slot after the LSB of a complete right-channel word.
  task automatic drive_half(input logic lr, input int len, input bit play,
                            input logic [DW-1:0] smp, input int rst_slot);
    exp_t e;
    bit   live;
    for (int j = 1; j <= len; j++) begin
      live   = play && (rst_slot == 0 || j <= rst_slot);
      e.dat  = 1'b0;
      if (live && j >= 2 && j <= int'(DW) + 1) e.dat = smp[int'(DW) + 1 - j];
      e.busy = live && (j <= int'(DW) + 1);
      e.done = (live && lr && j == int'(DW) + 2) ? 8'd1 : 8'd0;
      exp_q.push_back(e);

      bclk = 1'b0;
      if (j == 1) begin
        lrck = lr;
        if (!lr) begin
          en   = play;
          data = play ? smp : DW'($urandom);
        end else begin
          en   = 1'b0;
          data = 'x;
        end
      end
      repeat (4) @(negedge clk);
      bclk = 1'b1;
      if (j == rst_slot) begin
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rst_dacdat", {31'd0, dacdat}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_frame_done", {31'd0, fdone}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
      end else begin
        repeat (4) @(negedge clk);
      end
    end
  endtask

  task automatic drive_frame(input int len_l, input int len_r, input bit play,
                             input logic [DW-1:0] smp, input int rst_slot);
    drive_half(1'b0, len_l, play, smp, rst_slot);
    drive_half(1'b1, len_r, play && (rst_slot == 0), smp, 0);
  endtask

  initial begin : stim
    int          ll, lr_len;
    bit          pl;
    logic [DW-1:0] s;
    rst_n = 1'b0;
    en    = 1'b0;
    bclk  = 1'b1;
    lrck  = 1'b1;
    data  = '0;
    repeat (3) @(negedge clk);
    check("reset_dacdat", {31'd0, dacdat}, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_frame_done", {31'd0, fdone}, 32'd0);
    rst_n = 1'b1;
    drive_half(1'b1, 8, 1'b0, '0, 0);

    drive_frame(32, 32, 1'b1, 16'hA5C3, 0);
    drive_frame(32, 32, 1'b1, 16'h8000, 0);
    drive_frame(32, 32, 1'b1, 16'h0001, 0);
    for (int i = 0; i < 4; i++) drive_frame(32, 32, 1'b0, DW'($urandom), 0);
    for (int i = 0; i < 3; i++) drive_frame(8, 8, 1'b1, DW'($urandom), 0);
    drive_frame(32, 32, 1'b1, DW'($urandom), 7);
    drive_frame(32, 32, 1'b1, DW'($urandom), 0);
    for (int i = 0; i < 12; i++) begin
      ll     = int'($urandom_range(6, 40));
      lr_len = int'($urandom_range(6, 40));
      pl     = ($urandom_range(0, 3) != 0);
      s      = DW'($urandom);
      drive_frame(ll, lr_len, pl, s, 0);
    end
    drive_frame(32, 32, 1'b1, 16'hA5C3, 0);

    repeat (8) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
